conv2_seq: RTL and testbench

- Sequencer for the second convolution layer datapath: 4 input channels, 5-tap kernels, 8 output channels, combinational result.
- Reads the layer-1 feature map one sample position at a time (all 4 channels per word) from the inter-layer buffer.
- Maintains a 5-deep sliding window per channel and drives it into the datapath.
- Captures the 8 saturated int8 results per window position and writes them to the layer-2 output buffer, with start/busy/done control toward the top-level scheduler.

---
 rtl/conv2_seq.sv | 106 ++++++++++
 tb/tb_conv2_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_seq.sv
// Sequencer for the layer-2 convolution: streams 4-channel samples into 5-deep
// sliding windows, captures each combinational result and writes it out in order.
module conv2_seq #(
    parameter int IN_LEN = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              conv_en,
    output logic [39:0]       win_ch1,
    output logic [39:0]       win_ch2,
    output logic [39:0]       win_ch3,
    output logic [39:0]       win_ch4,
    input  logic [63:0]       conv_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    input  logic              wr_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // rptr is one bit wider than the address so it can reach IN_LEN itself.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(IN_LEN);

    logic [2:0]        state;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W-1:0] wptr;
    logic [2:0]        fill;
    logic [2:0]        fill_nxt;
    logic [3:0][39:0]  win;

    always_comb begin
        fill_nxt = (fill == 3'd5) ? 3'd5 : fill + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rptr    <= '0;
            wptr    <= '0;
            fill    <= '0;
            win     <= '0;
            wr_data <= '0;
            wr_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        rptr  <= '0;
                        wptr  <= '0;
                        fill  <= '0;
                    end
                end
                S_READ: state <= S_SHIFT;
                S_SHIFT: begin
                    // Newest sample enters at element 4; element 0 is the oldest.
                    for (int c = 0; c < 4; c++) begin
                        win[c] <= {rd_data[8*c +: 8], win[c][39:8]};
                    end
                    rptr  <= rptr + (ADDR_W+1)'(1);
                    fill  <= fill_nxt;
                    state <= (fill_nxt < 3'd5) ? S_READ : S_EVAL;
                end
                S_EVAL: begin
                    wr_data <= conv_res;
                    wr_addr <= wptr;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        wptr  <= wptr + ADDR_W'(1);
                        state <= (rptr == LAST) ? S_DONE : S_READ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign rd_en   = (state == S_READ);
    assign wr_en   = (state == S_WRITE);
    assign conv_en = (state == S_READ) || (state == S_SHIFT) ||
                     (state == S_EVAL) || (state == S_WRITE);
    assign rd_addr = rptr[ADDR_W-1:0];
    assign win_ch1 = win[0];
    assign win_ch2 = win[1];
    assign win_ch3 = win[2];
    assign win_ch4 = win[3];

endmodule

// File: tb/tb_conv2_seq.sv
// Bench for conv2_seq: IN_LEN=8 instance against a window/ordering model with
// randomized data and stalls, plus an IN_LEN=5 instance for the minimum case.
module tb_conv2_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start8 = 1'b0, start5 = 1'b0;

    logic        busy8, done8, rd_en8, conv_en8, wr_en8;
    logic [9:0]  rd_addr8, wr_addr8;
    logic [31:0] rd_data8 = '0;
    logic [39:0] w81, w82, w83, w84;
    logic [63:0] conv_res8, wr_data8;
    logic        wr_ready8 = 1'b1;

    logic        busy5, done5, rd_en5, conv_en5, wr_en5;
    logic [9:0]  rd_addr5, wr_addr5;
    logic [31:0] rd_data5 = '0;
    logic [39:0] w51, w52, w53, w54;
    logic [63:0] conv_res5, wr_data5;
    logic        wr_ready5 = 1'b1;

    int errors = 0, checks = 0;
    logic [31:0] mem8 [8];
    logic [31:0] mem5 [8];
    logic [63:0] exp_q[$];
    int          addr_q[$];
    int rd_cnt = 0, wr_cnt = 0, stall_at = -1, stall_len = 0, stall_done = 0, stall_seen = 0;
    bit rand_stall = 0, first_seen = 0, holding = 0;
    logic [63:0] first_data, held_data;
    logic [39:0] first_win1;
    logic [9:0]  held_addr;
    int p_cmp;

    conv2_seq #(.IN_LEN(8), .ADDR_W(10)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8), .conv_en(conv_en8),
        .win_ch1(w81), .win_ch2(w82), .win_ch3(w83), .win_ch4(w84),
        .conv_res(conv_res8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .wr_ready(wr_ready8)
    );

    conv2_seq #(.IN_LEN(5), .ADDR_W(10)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
        .rd_en(rd_en5), .rd_addr(rd_addr5), .rd_data(rd_data5), .conv_en(conv_en5),
        .win_ch1(w51), .win_ch2(w52), .win_ch3(w53), .win_ch4(w54),
        .conv_res(conv_res5), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .wr_ready(wr_ready5)
    );

    // Datapath stub: mixes elements from several channels and window positions.
    function automatic logic [63:0] stub(input logic [39:0] a, b, c, d);
        return {d[39:32], c[31:24], b[23:16], a[15:8], d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Expected window for output position p, channel c: samples p..p+4, k=0 oldest.
    function automatic logic [39:0] ewin(input logic [31:0] m [8], input int p, input int c);
        logic [39:0] r;
        for (int k = 0; k < 5; k++) r[8*k +: 8] = m[p+k][8*c +: 8];
        return r;
    endfunction

    assign conv_res8 = stub(w81, w82, w83, w84);
    assign conv_res5 = stub(w51, w52, w53, w54);

    always @(posedge clk) begin
        if (rd_en8) rd_data8 <= mem8[rd_addr8[2:0]];
        if (rd_en5) rd_data5 <= mem5[rd_addr5[2:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output-buffer driver and per-cycle compare for the IN_LEN=8 instance.
    always @(negedge clk) begin
        if (rst) begin
            wr_ready8 = 1'b1;
        end else begin
            if (wr_en8 && wr_cnt == stall_at && stall_done < stall_len) begin
                wr_ready8 = 1'b0;
                stall_done++;
            end else if (wr_en8 && rand_stall) wr_ready8 = 1'($urandom_range(0, 1));
            else wr_ready8 = 1'b1;
            if (wr_en8 && !wr_ready8) stall_seen++;

            chk("conv_en", conv_en8, busy8 && !done8);
            if (done8) chk("done_without_busy", busy8, 1);
            if (rd_en8 && wr_en8) chk("rd_during_write", 1, 0);
            if (rd_en8) begin
                chk("rd_addr", rd_addr8, rd_cnt % 8);
                rd_cnt++;
            end
            if (wr_en8) begin
                if (holding) begin
                    chk("hold_addr", wr_addr8, held_addr);
                    chk("hold_data", wr_data8, held_data);
                end else begin
                    holding   = 1;
                    held_addr = wr_addr8;
                    held_data = wr_data8;
                end
                if (wr_ready8) begin
                    holding = 0;
                    wr_cnt++;
                    if (exp_q.size() == 0) chk("extra_write", 1, 0);
                    else begin
                        p_cmp = addr_q.pop_front();
                        chk("wr_addr", wr_addr8, p_cmp);
                        chk("wr_data", wr_data8, exp_q.pop_front());
                        chk("win_ch1", w81, ewin(mem8, p_cmp, 0));
                        chk("win_ch2", w82, ewin(mem8, p_cmp, 1));
                        chk("win_ch3", w83, ewin(mem8, p_cmp, 2));
                        chk("win_ch4", w84, ewin(mem8, p_cmp, 3));
                        if (!first_seen) begin
                            first_seen = 1;
                            first_data = wr_data8;
                            first_win1 = w81;
                        end
                    end
                end
            end
        end
    end

    task automatic load_exp();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(stub(ewin(mem8, p, 0), ewin(mem8, p, 1), ewin(mem8, p, 2), ewin(mem8, p, 3)));
            addr_q.push_back(p);
        end
    endtask

    task automatic clear_counters();
        wr_cnt = 0; rd_cnt = 0; stall_done = 0; stall_seen = 0;
        first_seen = 0; holding = 0;
    endtask

    task automatic rand_mem8();
        for (int n = 0; n < 8; n++) mem8[n] = $urandom;
    endtask

    task automatic run_pass(output int bcnt);
        int dcnt, g;
        clear_counters();
        load_exp();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bcnt = 0; dcnt = 0; g = 0;
        while (busy8 && g < 1000) begin
            bcnt++;
            if (done8) dcnt++;
            @(negedge clk);
            g++;
        end
        if (g >= 1000) chk("timeout_pass", 1, 0);
        chk("busy_cycles", bcnt, 25 + stall_seen);
        chk("done_pulses", dcnt, 1);
        chk("writes_left", exp_q.size(), 0);
        chk("read_count", rd_cnt, 8);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy8, 0);
        chk({tag, "_done"}, done8, 0);
        chk({tag, "_rd_en"}, rd_en8, 0);
        chk({tag, "_wr_en"}, wr_en8, 0);
        chk({tag, "_conv_en"}, conv_en8, 0);
        chk({tag, "_rd_addr"}, rd_addr8, 0);
        chk({tag, "_wr_addr"}, wr_addr8, 0);
        chk({tag, "_wr_data"}, wr_data8, 0);
        chk({tag, "_win"}, {w81, w82, w83, w84}, 0);
    endtask

    initial begin
        int b, d, idle, g, r5, w5;
        for (int n = 0; n < 8; n++) mem8[n] = {8'(n + 3), 8'(n + 2), 8'(n + 1), 8'(n)};
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_busy5", busy5, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp data: hand-computed window and result at position 0.
        run_pass(b);
        chk("busy_25", b, 25);
        chk("first_win1", first_win1, 40'h04_03_02_01_00);
        chk("first_data", first_data, 64'h07050301_03020100);

        // Seven-cycle stall on the second write.
        rand_mem8();
        stall_at = 1; stall_len = 7;
        run_pass(b);
        chk("busy_32", b, 32);
        chk("stall_cycles", stall_seen, 7);
        stall_at = -1; stall_len = 0;

        // Random data with random back-pressure.
        rand_stall = 1;
        repeat (4) begin
            rand_mem8();
            run_pass(b);
        end
        rand_stall = 0;

        // Reset during SHIFT of the third sample, then a full clean pass.
        rand_mem8();
        clear_counters();
        load_exp();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        g = 0;
        while (!(rd_en8 && rd_addr8 == 10'd2) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("timeout_third_read", 1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        holding = 0;
        @(negedge clk);
        run_pass(b);

        // Start pulsed mid-pass is ignored; start held through DONE relaunches once.
        rand_mem8();
        clear_counters();
        load_exp();
        load_exp();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        b = 0; d = 0; idle = 0; g = 0;
        while (!(d == 2 && !busy8) && g < 300) begin
            if (busy8) b++; else idle++;
            if (done8) begin
                d++;
                if (d == 1) start8 = 1'b1;
            end else if (d == 1 && busy8) start8 = 1'b0;
            else if (g == 6) start8 = 1'b1;
            else if (g == 7) start8 = 1'b0;
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk("timeout_relaunch", 1, 0);
        chk("relaunch_busy", b, 50);
        chk("relaunch_idle_gap", idle, 1);
        chk("relaunch_reads", rd_cnt, 16);
        chk("relaunch_writes", wr_cnt, 8);
        chk("relaunch_left", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("no_extra_launch", busy8, 0);

        // Minimum length instance.
        for (int n = 0; n < 8; n++) mem5[n] = $urandom;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        b = 0; d = 0; r5 = 0; w5 = 0; g = 0;
        while (busy5 && g < 200) begin
            b++;
            if (done5) d++;
            if (rd_en5) begin
                chk("rd_addr5", rd_addr5, r5);
                r5++;
            end
            if (wr_en5) begin
                w5++;
                chk("wr_addr5", wr_addr5, 0);
                chk("wr_data5", wr_data5, stub(ewin(mem5, 0, 0), ewin(mem5, 0, 1),
                                               ewin(mem5, 0, 2), ewin(mem5, 0, 3)));
            end
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("timeout_len5", 1, 0);
        chk("busy5_13", b, 13);
        chk("done5_pulses", d, 1);
        chk("reads5", r5, 5);
        chk("writes5", w5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
